// File: rtl/stream_resize.sv
// rtl/stream_resize.sv - AXI-Stream byte-width converter with packet-exact boundaries
// Bytes pack into a shift-down buffer; load and unload may share a cycle.
module stream_resize #(
  parameter  int IN_BYTES  = 16,
  parameter  int OUT_BYTES = 8,
  localparam int BUF_BYTES = IN_BYTES + OUT_BYTES,
  localparam int CW        = $clog2(BUF_BYTES + 1)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [8*IN_BYTES-1:0]  in_data,
  input  logic [IN_BYTES-1:0]    in_keep,
  input  logic                   in_last,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [8*OUT_BYTES-1:0] out_data,
  output logic [OUT_BYTES-1:0]   out_keep,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   error_keep,
  output logic [CW-1:0]          bytes_held
);

  localparam logic [CW-1:0] OUT_C = CW'(OUT_BYTES);

  logic [8*BUF_BYTES-1:0] pack_q, pack_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   last_pend_q, last_pend_d;
  logic                   err_q, err_d;
  logic                   in_rst_q;
  logic [CW-1:0]          n_in;
  logic                   keep_bad;
  logic                   load, unload;

  // Length of the contiguous run of ones from bit 0; any later one is malformed.
  always_comb begin
    logic run;
    run      = 1'b1;
    n_in     = '0;
    keep_bad = 1'b0;
    for (int i = 0; i < IN_BYTES; i++) begin
      if (!in_keep[i])
        run = 1'b0;
      else if (run)
        n_in = n_in + CW'(1);
      else
        keep_bad = 1'b1;
    end
  end

  assign in_ready   = !in_rst_q && !last_pend_q && (count_q <= OUT_C);
  assign out_valid  = (count_q >= OUT_C) || (last_pend_q && (count_q != '0));
  assign out_last   = last_pend_q && (count_q <= OUT_C);
  assign out_data   = pack_q[8*OUT_BYTES-1:0];
  assign error_keep = err_q;
  assign bytes_held = count_q;

  always_comb begin
    out_keep = '0;
    for (int i = 0; i < OUT_BYTES; i++)
      out_keep[i] = (count_q > CW'(i));
  end

  assign load   = in_valid && in_ready;
  assign unload = out_valid && out_ready;

  // Unload first, then append the new beat right behind the surviving bytes.
  always_comb begin
    logic [CW-1:0] base;
    pack_d      = pack_q;
    base        = count_q;
    last_pend_d = last_pend_q;
    err_d       = err_q || (load && keep_bad);
    if (unload) begin
      pack_d = pack_q >> (8*OUT_BYTES);
      base   = (count_q >= OUT_C) ? (count_q - OUT_C) : '0;
      if (out_last)
        last_pend_d = 1'b0;
    end
    count_d = base;
    if (load) begin
      for (int i = 0; i < IN_BYTES; i++) begin
        if (CW'(i) < n_in)
          pack_d[(int'(base) + i)*8 +: 8] = in_data[i*8 +: 8];
      end
      count_d = base + n_in;
      if (in_last && (count_d != '0))
        last_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pack_q      <= '0;
      count_q     <= '0;
      last_pend_q <= 1'b0;
      err_q       <= 1'b0;
      in_rst_q    <= 1'b1;
    end else begin
      pack_q      <= pack_d;
      count_q     <= count_d;
      last_pend_q <= last_pend_d;
      err_q       <= err_d;
      in_rst_q    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_resize.sv
// tb/tb_stream_resize.sv - directed bench for stream_resize in three width pairings
module tb_stream_resize;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // DUT A: IN=16, OUT=8
  logic [127:0] a_in_data;  logic [15:0] a_in_keep; logic a_in_last, a_in_valid, a_in_ready;
  logic [63:0]  a_out_data; logic [7:0]  a_out_keep; logic a_out_last, a_out_valid, a_out_ready;
  logic a_err; logic [4:0] a_held;
  // DUT B: IN=8, OUT=12
  logic [63:0] b_in_data;   logic [7:0]  b_in_keep; logic b_in_last, b_in_valid, b_in_ready;
  logic [95:0] b_out_data;  logic [11:0] b_out_keep; logic b_out_last, b_out_valid, b_out_ready;
  logic b_err; logic [4:0] b_held;
  // DUT C: IN=OUT=8
  logic [63:0] c_in_data;   logic [7:0]  c_in_keep; logic c_in_last, c_in_valid, c_in_ready;
  logic [63:0] c_out_data;  logic [7:0]  c_out_keep; logic c_out_last, c_out_valid, c_out_ready;
  logic c_err; logic [4:0] c_held;

  stream_resize #(.IN_BYTES(16), .OUT_BYTES(8)) u_a (
    .clock(clock), .reset_n(reset_n),
    .in_data(a_in_data), .in_keep(a_in_keep), .in_last(a_in_last), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_keep(a_out_keep), .out_last(a_out_last), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .error_keep(a_err), .bytes_held(a_held));

  stream_resize #(.IN_BYTES(8), .OUT_BYTES(12)) u_b (
    .clock(clock), .reset_n(reset_n),
    .in_data(b_in_data), .in_keep(b_in_keep), .in_last(b_in_last), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_keep(b_out_keep), .out_last(b_out_last), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .error_keep(b_err), .bytes_held(b_held));

  stream_resize #(.IN_BYTES(8), .OUT_BYTES(8)) u_c (
    .clock(clock), .reset_n(reset_n),
    .in_data(c_in_data), .in_keep(c_in_keep), .in_last(c_in_last), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .out_data(c_out_data), .out_keep(c_out_keep), .out_last(c_out_last), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .error_keep(c_err), .bytes_held(c_held));

  typedef struct {
    logic        vld;
    logic [15:0] keep;
    logic        last;
    logic [7:0]  ds;
    logic        ordy;
    logic        e_rdy;
    logic        e_vld;
    logic [7:0]  e_keep;
    logic        e_last;
    logic [7:0]  e_ds;
    logic [4:0]  e_held;
    logic        e_err;
  } vec_t;

  vec_t tbl[30];

  function automatic vec_t v(input logic vld, input logic [15:0] keep, input logic last, input logic [7:0] ds,
                             input logic ordy, input logic e_rdy, input logic e_vld, input logic [7:0] e_keep,
                             input logic e_last, input logic [7:0] e_ds, input logic [4:0] e_held, input logic e_err);
    vec_t r;
    r.vld = vld; r.keep = keep; r.last = last; r.ds = ds; r.ordy = ordy;
    r.e_rdy = e_rdy; r.e_vld = e_vld; r.e_keep = e_keep; r.e_last = e_last;
    r.e_ds = e_ds; r.e_held = e_held; r.e_err = e_err;
    return r;
  endfunction

  function automatic logic [127:0] seq16(input logic [7:0] s);
    logic [127:0] r;
    for (int j = 0; j < 16; j++) r[j*8 +: 8] = s + 8'(j);
    return r;
  endfunction

  function automatic logic [63:0] seq8(input logic [7:0] s);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[j*8 +: 8] = s + 8'(j);
    return r;
  endfunction

  function automatic logic [63:0] exp8(input logic [7:0] s, input logic [7:0] keep);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[j*8 +: 8] = keep[j] ? s + 8'(j) : 8'h00;
    return r;
  endfunction

  function automatic logic [95:0] exp12(input logic [7:0] s, input logic [11:0] keep);
    logic [95:0] r;
    for (int j = 0; j < 12; j++) r[j*8 +: 8] = keep[j] ? s + 8'(j) : 8'h00;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, " in_ready"},   128'(a_in_ready),  128'(0));
    chk({tag, " out_valid"},  128'(a_out_valid), 128'(0));
    chk({tag, " out_last"},   128'(a_out_last),  128'(0));
    chk({tag, " out_keep"},   128'(a_out_keep),  128'(0));
    chk({tag, " out_data"},   128'(a_out_data),  128'(0));
    chk({tag, " error_keep"}, 128'(a_err),       128'(0));
    chk({tag, " bytes_held"}, 128'(a_held),      128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [95:0] bd[3];
    logic [11:0] bk[3];
    logic        bl[3];
    int          got;
    int          sent;

    a_in_data = '0; a_in_keep = '0; a_in_last = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    b_in_data = '0; b_in_keep = '0; b_in_last = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    c_in_data = '0; c_in_keep = '0; c_in_last = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b1;

    // vld keep last ds ordy | rdy vld keep last ds held err
    tbl[0]  = v(1'b1, 16'hFFFF, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 5'd0,  1'b0);
    tbl[1]  = v(1'b1, 16'hFFFF, 1'b0, 8'h10, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 5'd16, 1'b0);
    tbl[2]  = v(1'b1, 16'hFFFF, 1'b0, 8'h10, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h08, 5'd8,  1'b0);
    tbl[3]  = v(1'b1, 16'hFFFF, 1'b0, 8'h20, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h10, 5'd16, 1'b0);
    tbl[4]  = v(1'b1, 16'hFFFF, 1'b0, 8'h20, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h18, 5'd8,  1'b0);
    tbl[5]  = v(1'b1, 16'hFFFF, 1'b1, 8'h30, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h20, 5'd16, 1'b0);
    tbl[6]  = v(1'b1, 16'hFFFF, 1'b1, 8'h30, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h28, 5'd8,  1'b0);
    tbl[7]  = v(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h30, 5'd16, 1'b0);
    tbl[8]  = v(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 8'h38, 5'd8,  1'b0);
    tbl[9]  = v(1'b1, 16'hFFFF, 1'b0, 8'h40, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 5'd0,  1'b0);
    for (int i = 10; i < 20; i++)
      tbl[i] = v(1'b1, 16'hFFFF, 1'b1, 8'h50, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h40, 5'd16, 1'b0);
    tbl[20] = v(1'b1, 16'hFFFF, 1'b1, 8'h50, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h40, 5'd16, 1'b0);
    tbl[21] = v(1'b1, 16'hFFFF, 1'b1, 8'h50, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h48, 5'd8,  1'b0);
    tbl[22] = v(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h50, 5'd16, 1'b0);
    tbl[23] = v(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 8'h58, 5'd8,  1'b0);
    tbl[24] = v(1'b1, 16'h0005, 1'b0, 8'h60, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 5'd0,  1'b0);
    tbl[25] = v(1'b1, 16'h0000, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 8'h60, 5'd1,  1'b1);
    tbl[26] = v(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 8'h60, 5'd1,  1'b1);
    tbl[27] = v(1'b1, 16'h0000, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 5'd0,  1'b1);
    tbl[28] = v(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 5'd0,  1'b1);
    tbl[29] = v(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 5'd0,  1'b1);

    repeat (3) @(negedge clock);
    chk_a_zero("reset");
    chk("reset b in_ready", 128'(b_in_ready), 128'(0));
    chk("reset c in_ready", 128'(c_in_ready), 128'(0));
    reset_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      chk($sformatf("row%0d in_ready", i),   128'(a_in_ready),  128'(tbl[i].e_rdy));
      chk($sformatf("row%0d out_valid", i),  128'(a_out_valid), 128'(tbl[i].e_vld));
      chk($sformatf("row%0d out_keep", i),   128'(a_out_keep),  128'(tbl[i].e_keep));
      chk($sformatf("row%0d out_last", i),   128'(a_out_last),  128'(tbl[i].e_last));
      chk($sformatf("row%0d out_data", i),   128'(a_out_data),  128'(exp8(tbl[i].e_ds, tbl[i].e_keep)));
      chk($sformatf("row%0d bytes_held", i), 128'(a_held),      128'(tbl[i].e_held));
      chk($sformatf("row%0d error_keep", i), 128'(a_err),       128'(tbl[i].e_err));
      a_in_valid  = tbl[i].vld;
      a_in_keep   = tbl[i].keep;
      a_in_last   = tbl[i].last;
      a_in_data   = seq16(tbl[i].ds);
      a_out_ready = tbl[i].ordy;
    end
    a_in_valid = 1'b0;

    // IN=8, OUT=12: 27-byte packet ending in a partial beat
    got = 0; sent = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clock);
      if (b_out_valid) begin
        if (got < 3) begin
          bd[got] = b_out_data; bk[got] = b_out_keep; bl[got] = b_out_last;
        end
        got++;
      end
      if (sent < 4) begin
        b_in_valid = 1'b1;
        b_in_data  = seq8(8'(8*sent));
        b_in_keep  = (sent == 3) ? 8'h07 : 8'hFF;
        b_in_last  = (sent == 3);
        if (b_in_ready) sent++;
      end else begin
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
      end
    end
    chk("b beat count", 128'(got), 128'(3));
    if (got >= 3) begin
      chk("b beat0 keep", 128'(bk[0]), 128'(12'hFFF));
      chk("b beat1 keep", 128'(bk[1]), 128'(12'hFFF));
      chk("b beat2 keep", 128'(bk[2]), 128'(12'h007));
      chk("b beat0 last", 128'(bl[0]), 128'(0));
      chk("b beat1 last", 128'(bl[1]), 128'(0));
      chk("b beat2 last", 128'(bl[2]), 128'(1));
      chk("b beat0 data", 128'(bd[0]), 128'(exp12(8'h00, 12'hFFF)));
      chk("b beat1 data", 128'(bd[1]), 128'(exp12(8'h0C, 12'hFFF)));
      chk("b beat2 data", 128'(bd[2]), 128'(exp12(8'h18, 12'h007)));
    end

    // IN=OUT=8: 100 back-to-back beats, one per clock, latency one cycle
    for (int i = 0; i <= 101; i++) begin
      @(negedge clock);
      if (i >= 1 && i <= 100) begin
        chk($sformatf("c%0d out_valid", i),  128'(c_out_valid), 128'(1));
        chk($sformatf("c%0d out_data", i),   128'(c_out_data),  128'(seq8(8'(8*(i-1)))));
        chk($sformatf("c%0d bytes_held", i), 128'(c_held),      128'(8));
        chk($sformatf("c%0d out_last", i),   128'(c_out_last),  128'(i == 100));
      end
      if (i < 100) begin
        chk($sformatf("c%0d in_ready", i), 128'(c_in_ready), 128'(1));
        c_in_valid = 1'b1;
        c_in_keep  = 8'hFF;
        c_in_data  = seq8(8'(8*i));
        c_in_last  = (i == 99);
      end else begin
        c_in_valid = 1'b0;
        c_in_last  = 1'b0;
      end
      if (i == 101) begin
        chk("c end out_valid", 128'(c_out_valid), 128'(0));
        chk("c end bytes_held", 128'(c_held), 128'(0));
      end
    end

    // Reset with 5 bytes held and no packet end
    @(negedge clock);
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_keep = 16'h001F; a_in_last = 1'b0; a_in_data = seq16(8'h70);
    @(negedge clock);
    a_in_valid = 1'b0;
    chk("rst pre bytes_held", 128'(a_held), 128'(5));
    chk("rst pre out_valid", 128'(a_out_valid), 128'(0));
    reset_n = 1'b0;
    @(negedge clock);
    chk_a_zero("rst mid");
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst post in_ready", 128'(a_in_ready), 128'(1));
    chk("rst post out_valid", 128'(a_out_valid), 128'(0));
    chk("rst post bytes_held", 128'(a_held), 128'(0));
    a_in_valid = 1'b1; a_in_keep = 16'h00FF; a_in_last = 1'b1; a_in_data = seq16(8'h80);
    @(negedge clock);
    a_in_valid = 1'b0; a_in_last = 1'b0;
    chk("rst next out_valid", 128'(a_out_valid), 128'(1));
    chk("rst next out_keep", 128'(a_out_keep), 128'(8'hFF));
    chk("rst next out_last", 128'(a_out_last), 128'(1));
    chk("rst next out_data", 128'(a_out_data), 128'(exp8(8'h80, 8'hFF)));
    chk("rst next bytes_held", 128'(a_held), 128'(8));
    @(negedge clock);
    chk("rst drain out_valid", 128'(a_out_valid), 128'(0));
    chk("rst drain bytes_held", 128'(a_held), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
